golife_ctrl: RTL and testbench
==============================

// Module: golife_ctrl
// PURPOSE
//  Upstream sequencer for the golife cell array. Accepts an initial pattern one row per
//  valid/ready beat and assembles it into the ingrid bus. Then pulses load once.
//  Then issues a programmed number of single-cycle run strobes, spaced by a programmable
//  gap, and reports completion. Outputs ingrid/load/run drive the array directly.
// PARAMETERS
//  SIDEWIDTH  10  grid side length; must match the array instance
//  GENW       16  width of generation count (max GENW'b1...1 generations)
//  PERW       8   width of gap between run strobes (idle cycles)
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    asynchronous, active-low reset
//  start      in   1                    begin fill sequence; sampled in IDLE only
//  abort      in   1                    return to IDLE from any state
//  gens       in   GENW                 generations to run; latched on accepted start
//  period     in   PERW                 idle cycles between run strobes; latched on start
//  row_valid  in   1                    row_data valid
//  row_ready  out  1                    ctrl accepts a row this cycle
//  row_data   in   SIDEWIDTH            pattern row; rows arrive in order 0..SIDEWIDTH-1
//  ingrid     out  SIDEWIDTH*SIDEWIDTH  [SIDEWIDTH-1:0][SIDEWIDTH-1:0]; row r = ingrid[r]
//  load       out  1                    one-cycle load strobe to array
//  run        out  1                    one-cycle generation strobe to array
//  busy       out  1                    state != IDLE
//  done       out  1                    one-cycle pulse; sequence complete
//  gen_count  out  GENW                 run strobes issued since last accepted start
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE. ingrid=0, gen_count=0.
//    load, run, done, row_ready and busy are all 0.
//  FSM states: IDLE, FILL, LOAD, RUN, DONE. Outputs are Moore-decoded from registered state.
//  IDLE: row_ready=0. start=1 & abort=0 -> FILL.
//    On that start: row_idx=0, gen_count=0, latch gens/period.
//    start=1 & abort=1 -> stay IDLE.
//  FILL: row_ready=1. A beat is row_valid & row_ready.
//    Each beat writes ingrid[row_idx]<=row_data and increments row_idx.
//    Beat with row_idx==SIDEWIDTH-1 -> LOAD. No beat -> hold; gaps in row_valid are legal.
//    Rows not yet rewritten keep their previous contents.
//  LOAD: load=1 for exactly one cycle. ingrid is stable from this cycle on.
//    gens_l==0 -> DONE. Otherwise -> RUN with timer=period_l.
//  RUN: run=1 iff timer==0. On that cycle: gen_count++ and timer reloads to period_l.
//    If gen_count+1==gens_l -> DONE. While timer!=0: timer--, run=0.
//    Timing: load cycle at L; first run at L+1+period; then every period+1 cycles.
//    period=0 gives back-to-back run strobes.
//  DONE: done=1 for one cycle -> IDLE. gen_count and ingrid hold until next accepted start.
//  abort=1 in FILL/LOAD/RUN/DONE: next state IDLE, no done pulse.
//    Strobes decoded in the abort cycle itself still occur.
//    gen_count holds strobes issued so far. row_ready drops the cycle after abort.
//  start while busy: ignored; no re-latch.
//  Reset mid-operation: immediate return to reset values; ingrid cleared.
//  load and run are never high in the same cycle. row_ready is high only in FILL.
// TESTING
//  T1 reset: rst=0 mid-RUN -> same cycle all outputs 0, ingrid=0; after release busy=0.
//  T2 SIDEWIDTH=4, gens=3, period=2, rows 1,2,4,8 back-to-back:
//     -> ingrid={8,4,2,1}; load 1 cycle after 4th beat.
//     -> run at L+3, L+6, L+9; done at L+10; gen_count=3.
//  T3 row_valid toggling 1,0,0,1,...:
//     -> only valid&ready beats stored; load follows the 4th beat by one cycle.
//  T4 gens=0 -> load pulse, then done next cycle, run never asserted, gen_count=0.
//  T5 period=0, gens=5 -> five consecutive run cycles starting L+1, done at L+6.
//  T6 abort in RUN after 2 strobes -> IDLE next cycle, no done, gen_count=2.
//     start while busy ignored.

Source files
------------

// File: rtl/golife_ctrl.sv
// golife_ctrl: upstream sequencer for the golife cell array.
//
// The controller collects an initial pattern one row per valid/ready beat and
// assembles it onto the ingrid bus. It then pulses load once and issues a
// programmed number of single-cycle run strobes separated by a programmable
// idle gap. A one-cycle done pulse reports completion.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   start      in   begin a fill sequence (sampled in IDLE only)
//   abort      in   return to IDLE from any state, no done pulse
//   gens       in   generations to run, latched on accepted start
//   period     in   idle cycles between run strobes, latched on accepted start
//   row_valid  in   row_data valid
//   row_ready  out  a row is accepted this cycle (high only in FILL)
//   row_data   in   pattern row, rows arrive in order 0..SIDEWIDTH-1
//   ingrid     out  assembled pattern, row r = ingrid[r]
//   load       out  one-cycle load strobe to the array
//   run        out  one-cycle generation strobe to the array
//   busy       out  state != IDLE
//   done       out  one-cycle completion pulse
//   gen_count  out  run strobes issued since the last accepted start
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; ingrid and gen_count hold
// FILL   | accepting pattern rows on the valid/ready handshake
// LOAD   | single-cycle load strobe; ingrid stable from here on
// RUN    | timer counts down the gap; run strobe when it reaches zero
// DONE   | single-cycle done pulse, then back to IDLE

module golife_ctrl #(
  parameter int SIDEWIDTH = 10,
  parameter int GENW      = 16,
  parameter int PERW      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [GENW-1:0]                      gens,
  input  logic [PERW-1:0]                      period,
  input  logic                                 row_valid,
  output logic                                 row_ready,
  input  logic [SIDEWIDTH-1:0]                 row_data,
  output logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0]  ingrid,
  output logic                                 load,
  output logic                                 run,
  output logic                                 busy,
  output logic                                 done,
  output logic [GENW-1:0]                      gen_count
);

  localparam int IDXW = (SIDEWIDTH > 1) ? $clog2(SIDEWIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(SIDEWIDTH - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [GENW-1:0] GEN_ONE  = GENW'(1);
  localparam logic [PERW-1:0] PER_ONE  = PERW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [IDXW-1:0]                     row_idx;
  logic [GENW-1:0]                     gens_l;
  logic [PERW-1:0]                     period_l;
  logic [PERW-1:0]                     timer;
  logic [GENW-1:0]                     gen_cnt_q;
  logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0] ingrid_q;

  logic accept;
  logic beat;
  logic last_row;
  logic timer_zero;
  logic last_gen;

  assign accept     = (state == S_IDLE) && start && !abort;
  assign beat       = (state == S_FILL) && row_valid;
  assign last_row   = (row_idx == IDX_LAST);
  assign timer_zero = (timer == '0);
  // Compared in GENW bits so the all-ones generation count still terminates.
  assign last_gen   = ((gen_cnt_q + GEN_ONE) == gens_l);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_FILL;
      S_FILL: if (beat && last_row) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (gens_l == '0) ? S_DONE : S_RUN;
      S_RUN:  if (timer_zero && last_gen) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides every transition; strobes decoded this cycle still fire.
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  // Moore output decode
  always_comb begin
    row_ready = (state == S_FILL);
    load      = (state == S_LOAD);
    run       = (state == S_RUN) && timer_zero;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
  end

  // Datapath: row assembly, latched parameters, gap timer, strobe counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_idx   <= '0;
      gens_l    <= '0;
      period_l  <= '0;
      timer     <= '0;
      gen_cnt_q <= '0;
      ingrid_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            row_idx   <= '0;
            gen_cnt_q <= '0;
            gens_l    <= gens;
            period_l  <= period;
          end
        end
        S_FILL: begin
          if (beat) begin
            ingrid_q[row_idx] <= row_data;
            row_idx           <= row_idx + IDX_ONE;
          end
        end
        S_LOAD: timer <= period_l;
        S_RUN: begin
          if (timer_zero) begin
            gen_cnt_q <= gen_cnt_q + GEN_ONE;
            timer     <= period_l;
          end else begin
            timer <= timer - PER_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign ingrid    = ingrid_q;
  assign gen_count = gen_cnt_q;

endmodule

// File: tb/tb_golife_ctrl.sv
// Testbench for golife_ctrl with a 4x4 grid. Expected load/run/done strobes are
// pushed to a queue as the final row beat is driven and popped by a monitor as
// the DUT produces them; end-of-sequence state is checked from a vector table.

module tb_golife_ctrl;

  localparam int SW   = 4;
  localparam int GENW = 16;
  localparam int PERW = 8;

  localparam int EV_LOAD = 0;
  localparam int EV_RUN  = 1;
  localparam int EV_DONE = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [GENW-1:0]       gens = '0;
  logic [PERW-1:0]       period = '0;
  logic                  row_valid = 1'b0;
  logic                  row_ready;
  logic [SW-1:0]         row_data = '0;
  logic [SW-1:0][SW-1:0] ingrid;
  logic                  load, run, busy, done;
  logic [GENW-1:0]       gen_count;

  golife_ctrl #(.SIDEWIDTH(SW), .GENW(GENW), .PERW(PERW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gens(gens), .period(period),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .ingrid(ingrid), .load(load), .run(run), .busy(busy), .done(done),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rst && (load || run || done)) begin
      int kind;
      ev_t e;
      kind = load ? EV_LOAD : (run ? EV_RUN : EV_DONE);
      if (load && run) check("load_run_overlap", 64'(load & run), 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 64'(kind), 64'(e.kind));
        check("strobe_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Start, fill the grid (optionally with a 1,0,0 valid pattern) and queue the
  // expected strobes once the final beat is seen.
  task automatic run_seq(input logic [GENW-1:0] g, input logic [PERW-1:0] p,
                         input logic [SW-1:0][SW-1:0] rows, input bit toggle,
                         input int max_runs, input bit exp_done, output int lcyc);
    int idx, step;
    lcyc = 0;
    @(posedge clk); #1;
    gens = g; period = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; step = 0;
    while (idx < SW && step < 200) begin
      row_valid = toggle ? ((step % 3) == 0) : 1'b1;
      row_data  = rows[idx];
      @(negedge clk);
      if (row_valid && row_ready) begin
        if (idx == SW - 1) begin
          int nruns;
          lcyc = cyc + 1;
          exp_q.push_back('{EV_LOAD, lcyc});
          nruns = (int'(g) < max_runs) ? int'(g) : max_runs;
          for (int k = 1; k <= nruns; k++)
            exp_q.push_back('{EV_RUN, lcyc + k * (int'(p) + 1)});
          if (exp_done)
            exp_q.push_back('{EV_DONE, lcyc + int'(g) * (int'(p) + 1) + 1});
        end
        idx++;
      end
      @(posedge clk); #1;
      step++;
    end
    row_valid = 1'b0;
    if (idx < SW) begin
      tests++;
      fails++;
      $display("FAIL fill_timeout: got %0d rows expected %0d", idx, SW);
    end
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL strobe_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic [GENW-1:0]       g;
    logic [PERW-1:0]       p;
    logic [SW-1:0][SW-1:0] rows;
    bit                    toggle;
    logic [GENW-1:0]       exp_gc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lc;
    logic [SW-1:0][SW-1:0] prev;

    vecs[0] = '{16'd3, 8'd2, 16'h8421, 1'b0, 16'd3};  // rows 1,2,4,8 back-to-back
    vecs[1] = '{16'd2, 8'd1, 16'h5A3C, 1'b1, 16'd2};  // gappy row_valid
    vecs[2] = '{16'd0, 8'd4, 16'hF00F, 1'b0, 16'd0};  // zero generations
    vecs[3] = '{16'd5, 8'd0, 16'h1234, 1'b0, 16'd5};  // back-to-back runs
    vecs[4] = '{16'd1, 8'd7, 16'hFFFF, 1'b1, 16'd1};  // single run, long gap

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ingrid", 64'(ingrid), 64'd0);
    check("rst_strobes", 64'({load, run, done, row_ready}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_gen_count", 64'(gen_count), 64'd0);

    foreach (vecs[i]) begin
      run_seq(vecs[i].g, vecs[i].p, vecs[i].rows, vecs[i].toggle, 1 << 20, 1'b1, lc);
      wait_empty(300);
      @(negedge clk);
      check("vec_ingrid", 64'(ingrid), 64'(vecs[i].rows));
      check("vec_gen_count", 64'(gen_count), 64'(vecs[i].exp_gc));
      check("vec_busy_after", 64'(busy), 64'd0);
      check("vec_done_after", 64'(done), 64'd0);
    end

    // Abort in RUN after two strobes; a start while busy must not re-latch.
    run_seq(16'd5, 8'd1, 16'h0F0F, 1'b0, 2, 1'b0, lc);
    @(posedge clk); #1;
    gens = 16'd1; period = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < lc + 5) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_row_ready", 64'(row_ready), 64'd0);
    check("abort_gen_count", 64'(gen_count), 64'd2);
    check("abort_pending", 64'(exp_q.size()), 64'd0);
    repeat (8) @(posedge clk);
    check("abort_quiet_gen_count", 64'(gen_count), 64'd2);

    // Abort in FILL after two rows: unwritten rows keep their old contents.
    prev = ingrid;
    @(posedge clk); #1;
    gens = 16'd2; period = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; row_valid = 1'b1; row_data = 4'hA;
    @(posedge clk); #1;
    row_data = 4'h6;
    @(posedge clk); #1;
    row_valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("fill_abort_ingrid", 64'(ingrid), 64'({prev[3], prev[2], 4'h6, 4'hA}));
    check("fill_abort_gen_count", 64'(gen_count), 64'd0);
    check("fill_abort_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of RUN.
    run_seq(16'd5, 8'd3, 16'hC3A5, 1'b0, 1, 1'b0, lc);
    while (cyc < lc + 5) begin
      @(posedge clk); #1;
    end
    check("pre_rst_gen_count", 64'(gen_count), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ingrid", 64'(ingrid), 64'd0);
    check("mid_rst_gen_count", 64'(gen_count), 64'd0);
    check("mid_rst_outputs", 64'({load, run, done, row_ready, busy}), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_ingrid", 64'(ingrid), 64'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
